// File: rtl/key_conditioner_if.sv
// Push-button bundle between the board I/O side and the key conditioner.
// The master drives enable/raw keys; the slave returns level and pulse vectors.
interface key_conditioner_if #(
    parameter int unsigned N_KEYS = 5
);
    logic              enable;
    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_pulse;
    logic [N_KEYS-1:0] key_release;

    modport master (
        output enable,
        output key_raw,
        input  key_level,
        input  key_pulse,
        input  key_release
    );

    modport slave (
        input  enable,
        input  key_raw,
        output key_level,
        output key_pulse,
        output key_release
    );
endinterface

// File: rtl/key_conditioner.sv
// Per-key synchroniser, debouncer and hold-to-repeat pulse generator.
// Every channel is independent; all outputs come straight from flops.
module key_conditioner #(
    parameter int unsigned       N_KEYS          = 5,
    parameter int unsigned       DEBOUNCE_CYCLES = 16,
    parameter int unsigned       REPEAT_DELAY    = 32,
    parameter int unsigned       REPEAT_PERIOD   = 8,
    parameter logic [N_KEYS-1:0] REPEAT_MASK     = N_KEYS'(5'b00011)
) (
    input logic              clk,
    input logic              rst_n,
    key_conditioner_if.slave bus
);

    localparam int unsigned MAX_AB     = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int unsigned MAX_CYCLES = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int unsigned CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        logic          sync_a;
        logic          sync_b;
        logic          level;
        logic          pulse;
        logic          rel;
        logic [CW-1:0] deb_cnt;
        logic [CW-1:0] rep_cnt;
        logic [1:0]    state;
        logic          deb_done;
        logic          rise;
        logic          fall;

        assign deb_done = (sync_b != level) && (deb_cnt == DEB_LAST);
        assign rise     = deb_done && sync_b;
        assign fall     = deb_done && !sync_b;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_a <= 1'b0;
                sync_b <= 1'b0;
            end else begin
                sync_a <= bus.key_raw[i];
                sync_b <= sync_a;
            end
        end

        // Debounce keeps running regardless of enable so the level stays truthful.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                level   <= 1'b0;
                deb_cnt <= '0;
            end else if (sync_b == level) begin
                deb_cnt <= '0;
            end else if (deb_done) begin
                level   <= sync_b;
                deb_cnt <= '0;
            end else if (deb_cnt != '1) begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end

        // An accepted fall outranks a repeat landing on the same edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= ST_IDLE;
                rep_cnt <= '0;
                pulse   <= 1'b0;
                rel     <= 1'b0;
            end else if (!bus.enable) begin
                state   <= ST_IDLE;
                rep_cnt <= '0;
                pulse   <= 1'b0;
                rel     <= 1'b0;
            end else begin
                pulse <= 1'b0;
                rel   <= 1'b0;
                if (fall) begin
                    rel     <= 1'b1;
                    state   <= ST_IDLE;
                    rep_cnt <= '0;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            rep_cnt <= '0;
                            if (rise) begin
                                pulse <= 1'b1;
                                if (REPEAT_MASK[i]) state <= ST_DELAY;
                            end
                        end
                        ST_DELAY: begin
                            if (rep_cnt == DELAY_LAST) begin
                                pulse   <= 1'b1;
                                rep_cnt <= '0;
                                state   <= ST_REPEAT;
                            end else if (rep_cnt != '1) begin
                                rep_cnt <= rep_cnt + 1'b1;
                            end
                        end
                        ST_REPEAT: begin
                            if (rep_cnt == PERIOD_LAST) begin
                                pulse   <= 1'b1;
                                rep_cnt <= '0;
                            end else if (rep_cnt != '1) begin
                                rep_cnt <= rep_cnt + 1'b1;
                            end
                        end
                        default: begin
                            state   <= ST_IDLE;
                            rep_cnt <= '0;
                        end
                    endcase
                end
            end
        end

        assign bus.key_level[i]   = level;
        assign bus.key_pulse[i]   = pulse;
        assign bus.key_release[i] = rel;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/repeat timings.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_key_conditioner;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    key_conditioner_if #(.N_KEYS(5)) bus ();

    key_conditioner #(
        .N_KEYS          (5),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (6),
        .REPEAT_PERIOD   (3),
        .REPEAT_MASK     (5'b00011)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check3(input string tag, input logic [4:0] lvl, input logic [4:0] pls, input logic [4:0] rel);
        check({tag, " level"},   bus.key_level,   lvl);
        check({tag, " pulse"},   bus.key_pulse,   pls);
        check({tag, " release"}, bus.key_release, rel);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus.enable  = 1'b1;
        bus.key_raw = 5'b00000;

        // 1: reset state, then 50 quiet cycles
        for (int n = 1; n <= 3; n++) begin
            tick();
            check3($sformatf("reset n=%0d", n), 5'b0, 5'b0, 5'b0);
        end
        rst_n = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            tick();
            check3($sformatf("idle n=%0d", n), 5'b0, 5'b0, 5'b0);
        end

        // 2: rotate (no repeat) held 20 cycles
        bus.key_raw = 5'b00100;
        for (int n = 1; n <= 20; n++) begin
            tick();
            check3($sformatf("rot press n=%0d", n), (n >= 6) ? 5'b00100 : 5'b0,
                   (n == 6) ? 5'b00100 : 5'b0, 5'b0);
        end
        bus.key_raw = 5'b00000;
        for (int n = 1; n <= 10; n++) begin
            tick();
            check3($sformatf("rot release n=%0d", n), (n < 6) ? 5'b00100 : 5'b0,
                   5'b0, (n == 6) ? 5'b00100 : 5'b0);
        end

        // 3: move_left with repeat, press at n=6, repeats 12,15,18,21,24
        bus.key_raw = 5'b00001;
        for (int n = 1; n <= 20; n++) begin
            tick();
            check3($sformatf("left press n=%0d", n), (n >= 6) ? 5'b00001 : 5'b0,
                   (n == 6 || n == 12 || n == 15 || n == 18) ? 5'b00001 : 5'b0, 5'b0);
        end
        bus.key_raw = 5'b00000;
        for (int n = 1; n <= 12; n++) begin
            tick();
            check3($sformatf("left release n=%0d", n), (n < 6) ? 5'b00001 : 5'b0,
                   (n == 1 || n == 4) ? 5'b00001 : 5'b0, (n == 6) ? 5'b00001 : 5'b0);
        end

        // 4: three-cycle glitch on move_right is rejected
        bus.key_raw = 5'b00010;
        for (int n = 1; n <= 3; n++) begin
            tick();
            check3($sformatf("glitch hi n=%0d", n), 5'b0, 5'b0, 5'b0);
        end
        bus.key_raw = 5'b00000;
        for (int n = 1; n <= 12; n++) begin
            tick();
            check3($sformatf("glitch lo n=%0d", n), 5'b0, 5'b0, 5'b0);
        end

        // 5: left+right in lockstep; release lands on a repeat edge (n'=6)
        bus.key_raw = 5'b00011;
        for (int n = 1; n <= 21; n++) begin
            tick();
            check3($sformatf("pair press n=%0d", n), (n >= 6) ? 5'b00011 : 5'b0,
                   (n == 6 || n == 12 || n == 15 || n == 18 || n == 21) ? 5'b00011 : 5'b0, 5'b0);
        end
        bus.key_raw = 5'b00000;
        for (int n = 1; n <= 10; n++) begin
            tick();
            check3($sformatf("pair release n=%0d", n), (n < 6) ? 5'b00011 : 5'b0,
                   (n == 3) ? 5'b00011 : 5'b0, (n == 6) ? 5'b00011 : 5'b0);
        end

        // 6: enable dropped mid-REPEAT, raised while held, then release and re-press
        bus.key_raw = 5'b00001;
        for (int n = 1; n <= 14; n++) begin
            tick();
            check3($sformatf("en hold n=%0d", n), (n >= 6) ? 5'b00001 : 5'b0,
                   (n == 6 || n == 12) ? 5'b00001 : 5'b0, 5'b0);
        end
        bus.enable = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            check3($sformatf("en low n=%0d", n), 5'b00001, 5'b0, 5'b0);
        end
        bus.enable = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            tick();
            check3($sformatf("en high held n=%0d", n), 5'b00001, 5'b0, 5'b0);
        end
        bus.key_raw = 5'b00000;
        for (int n = 1; n <= 8; n++) begin
            tick();
            check3($sformatf("en release n=%0d", n), (n < 6) ? 5'b00001 : 5'b0,
                   5'b0, (n == 6) ? 5'b00001 : 5'b0);
        end
        bus.key_raw = 5'b00001;
        for (int n = 1; n <= 8; n++) begin
            tick();
            check3($sformatf("repress n=%0d", n), (n >= 6) ? 5'b00001 : 5'b0,
                   (n == 6) ? 5'b00001 : 5'b0, 5'b0);
        end

        // asynchronous reset while key 0 is still held
        #2;
        rst_n = 1'b0;
        #1;
        check3("async reset", 5'b0, 5'b0, 5'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            tick();
            check3($sformatf("post reset n=%0d", n), (n >= 6) ? 5'b00001 : 5'b0,
                   (n == 6) ? 5'b00001 : 5'b0, 5'b0);
        end
        bus.key_raw = 5'b00000;
        for (int n = 1; n <= 8; n++) begin
            tick();
            check3($sformatf("post reset release n=%0d", n), (n < 6) ? 5'b00001 : 5'b0,
                   (n == 5) ? 5'b00001 : 5'b0, (n == 6) ? 5'b00001 : 5'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Parametrised front-end for the player push-buttons (move_left, move_right, rotate, move_fast, move_tobottom and future keys). Each channel synchronises a raw asynchronous button level, debounces it, and emits single-cycle press/release pulses, with optional hold-to-repeat (auto-shift) per channel. It sits between the board I/O and Tetris_design, replacing ad-hoc one-cycle pulse assumptions on the game-control inputs.

## Interface
- N_KEYS, 5: number of independent key channels.
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised cycles required to accept a level change; ≥1.
- REPEAT_DELAY, 32: cycles from the press pulse to the first repeat pulse; ≥1.
- REPEAT_PERIOD, 8: cycles between subsequent repeat pulses; ≥1.
- REPEAT_MASK, 5'b00011: per-channel repeat enable; bit i=1 enables repeat on channel i.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  pulse gate; low while the game is in INITIAL or LOSE.
- key_raw  in  N_KEYS  raw, asynchronous button levels, active-high.
- key_level  out  N_KEYS  debounced level.
- key_pulse  out  N_KEYS  one-cycle pulse on accepted press and on each repeat.
- key_release  out  N_KEYS  one-cycle pulse on accepted release.

## Operation
- Reset: synchroniser flops, debounced level, counters and outputs all 0; every repeat FSM in IDLE.
- Per channel: 2-flop synchroniser → debounce → repeat FSM. Channels are fully independent; simultaneous events on several channels are each handled in the same cycle.
- Debounce: the counter clears whenever the synchronised value equals key_level. While they differ, the counter increments. On the edge where the counter equals DEBOUNCE_CYCLES-1, key_level flips and the counter clears. A glitch shorter than DEBOUNCE_CYCLES cycles never changes key_level.
- Counter width is sized to the largest of DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD. Counters saturate and never wrap.
- Repeat FSM states are IDLE, DELAY and REPEAT.
  - IDLE: on an accepted rise with enable=1, assert key_pulse. If the channel's REPEAT_MASK bit is set, go to DELAY with the counter at 0; otherwise stay in IDLE.
  - DELAY: the counter increments. On the edge where it equals REPEAT_DELAY-1, assert key_pulse, clear the counter and go to REPEAT.
  - REPEAT: the counter increments. On the edge where it equals REPEAT_PERIOD-1, assert key_pulse and clear the counter.
  - From any state, an accepted fall asserts key_release (if enable=1) and forces IDLE.
- enable=0: key_pulse and key_release are forced low, and every FSM is forced to IDLE with its counter cleared. key_level keeps tracking the input.
- enable rising while a key is held: no pulse is issued. A fresh press is required.
- Asynchronous reset mid-hold: all state clears immediately. After release of reset, a key that is still held is accepted as a new press after the normal debounce latency.

## Timing
- All outputs are registered.
- Let edge k be the first clock edge at which the synchroniser's first flop captures a new raw level that then stays stable. key_level changes at edge k+1+DEBOUNCE_CYCLES.
- key_pulse (press) and key_release are asserted for exactly one cycle, on the same edge that key_level changes.
- Repeat pulses: with the press pulse at edge P, repeats occur at P+REPEAT_DELAY, then P+REPEAT_DELAY+m·REPEAT_PERIOD for m≥1, until release is accepted.
- When release is accepted on the same edge a repeat would fire, only key_release is asserted; no key_pulse is issued.
- No combinational path from any input to any output.

## Test plan
All scenarios use the bench parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=6, REPEAT_PERIOD=3, N_KEYS=5, REPEAT_MASK=5'b00011.

1. Reset hold, then release with all keys low → all outputs 0 for 50 cycles.
2. rotate (bit 2) held 20 cycles, enable=1:
   - key_level[2] rises at edge k+5.
   - Exactly one key_pulse[2] on that edge; no repeats.
   - One key_release[2] at release edge +5.
3. move_left (bit 0) held 20 cycles → pulses at P, P+6, P+9, P+12, …; pulses stop at accepted release, and key_release[0] fires once.
4. Glitch: key_raw[1] high for 3 cycles → key_level[1], key_pulse[1] and key_release[1] stay 0 throughout.
5. move_left and move_right pressed in the same cycle → key_pulse[0] and key_pulse[1] assert on the same edge and repeat in lockstep.
6. Hold key 0 → drop enable mid-REPEAT → no further pulses. Raise enable while still held → no pulse. Release and re-press → a new pulse occurs with normal latency.
